// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
// Reset-time pattern defaults, legal pattern-length limits and the length-mask builder.
package seq_det_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;
    localparam int RST_LEN_DEF = 4;
    localparam logic [PAT_W_MAX-1:0] RST_PAT_DEF = 32'h0000_000B;

    // Ones in the low len bits; only these history bits take part in a compare.
    function automatic logic [PAT_W_MAX-1:0] len_mask(input int unsigned len);
        logic [PAT_W_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < PAT_W_MAX; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bundle of serial data, configuration and status signals for seq_detector_param.
// in_i is a sample only when valid_i is high; there is no ready, the detector accepts every valid bit.
interface seq_detector_param_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) ();

    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             in_i;
    logic             valid_i;
    logic             cfg_load_i;
    logic [PAT_W-1:0] cfg_pat_i;
    logic [LEN_W-1:0] cfg_len_i;
    logic             cfg_ovl_i;
    logic             clr_cnt_i;
    logic             match_o;
    logic [CNT_W-1:0] match_cnt_o;
    logic             cfg_err_o;

    modport master (
        output in_i, valid_i, cfg_load_i, cfg_pat_i, cfg_len_i, cfg_ovl_i, clr_cnt_i,
        input  match_o, match_cnt_o, cfg_err_o
    );

    modport slave (
        input  in_i, valid_i, cfg_load_i, cfg_pat_i, cfg_len_i, cfg_ovl_i, clr_cnt_i,
        output match_o, match_cnt_o, cfg_err_o
    );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter; a clear that coincides with an increment leaves the count at 1.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? W'(1) : '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-configurable serial pattern detector with overlapping/non-overlapping modes,
// a registered one-cycle match pulse, a saturating match counter and a sticky config error.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter int               CNT_W   = 16,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(RST_PAT_DEF),
    parameter int               RST_LEN = RST_LEN_DEF
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    seq_detector_param_if.slave bus
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic             r_match;
    logic             r_err;

    logic [PAT_W-1:0] w_shifted;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W:0]   w_fill_p1;
    logic             w_fill_ok;
    logic             w_cfg_ok;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt;

    // The compare uses the history as it will look once the current bit is shifted in.
    assign w_shifted = {r_hist[PAT_W-2:0], bus.in_i};
    assign w_mask    = PAT_W'(len_mask(32'(r_len)));
    assign w_fill_p1 = {1'b0, r_fill} + (LEN_W + 1)'(1);
    assign w_fill_ok = (w_fill_p1 >= {1'b0, r_len});
    assign w_cfg_ok  = (bus.cfg_len_i >= LEN_W'(PAT_W_MIN)) && (bus.cfg_len_i <= LEN_W'(PAT_W));

    // A load strobe swallows any bit presented with it, legal length or not.
    assign w_hit = bus.valid_i && !bus.cfg_load_i && w_fill_ok &&
                   (((w_shifted ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= RST_PAT;
            r_len   <= LEN_W'(RST_LEN);
            r_ovl   <= 1'b0;
            r_match <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (bus.cfg_load_i) begin
                if (w_cfg_ok) begin
                    r_pat  <= bus.cfg_pat_i;
                    r_len  <= bus.cfg_len_i;
                    r_ovl  <= bus.cfg_ovl_i;
                    r_hist <= '0;
                    r_fill <= '0;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (bus.valid_i) begin
                r_hist <= w_shifted;
                // Non-overlapping: restart the fill so no bit is reused by the next match.
                if (w_hit && !r_ovl) begin
                    r_fill <= '0;
                end else if (r_fill != LEN_W'(PAT_W)) begin
                    r_fill <= r_fill + LEN_W'(1);
                end
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .i_inc (w_hit),
        .i_clr (bus.clr_cnt_i),
        .o_cnt (w_cnt)
    );

    assign bus.match_o     = r_match;
    assign bus.match_cnt_o = w_cnt;
    assign bus.cfg_err_o   = r_err;

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The module SHALL provide the parameter PAT_W, default 8, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 The module SHALL provide the parameter CNT_W, default 16, giving the width of the match counter.
REQ-003 The module SHALL provide the parameter RST_PAT, default 8'b0000_1011, giving the pattern in effect after reset.
REQ-004 The module SHALL provide the parameter RST_LEN, default 4, giving the pattern length in effect after reset.
REQ-005 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port in_i, input, 1 bit: serial data bit.
REQ-008 Port valid_i, input, 1 bit: in_i is sampled only when valid_i is high.
REQ-009 Port cfg_load_i, input, 1 bit: single-cycle strobe that loads the pattern configuration.
REQ-010 Port cfg_pat_i, input, PAT_W bits: pattern; bit [len-1] is the first bit received and bit [0] the last.
REQ-011 Port cfg_len_i, input, $clog2(PAT_W+1) bits: active pattern length.
REQ-012 Port cfg_ovl_i, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping.
REQ-013 Port clr_cnt_i, input, 1 bit: synchronous clear of the match counter.
REQ-014 Port match_o, output, 1 bit: registered Moore match flag.
REQ-015 Port match_cnt_o, output, CNT_W bits: saturating count of matches.
REQ-016 Port cfg_err_o, output, 1 bit: sticky flag set when an illegal length is loaded.

Function
REQ-017 The block SHALL hold a PAT_W-bit history shift register; on every cycle with valid_i=1 it SHALL shift in_i into bit 0.
REQ-018 The block SHALL hold a fill counter that increments once per accepted bit and saturates at PAT_W.
REQ-019 A hit SHALL occur on an accepted bit when fill+1 >= len and the low len bits of {history[PAT_W-2:0], in_i} equal the low len bits of the pattern.
REQ-020 match_o SHALL be 1 for exactly the one cycle following the edge on which the hit bit was accepted, and 0 otherwise (one-cycle latency, no combinational path from in_i).
REQ-021 In overlapping mode, a hit SHALL leave the fill counter and history unchanged; e.g. pattern 101 on input 10101 gives two hits.
REQ-022 In non-overlapping mode, a hit SHALL reset the fill counter to 0 so that no bit contributes to two matches; e.g. pattern 101 on input 10101 gives one hit.
REQ-023 Cycles with valid_i=0 SHALL leave the history, the fill counter and the counter unchanged, and SHALL drive match_o to 0.
REQ-024 A cfg_load_i strobe with 2 <= cfg_len_i <= PAT_W SHALL latch pattern, length and mode, and SHALL clear the history and the fill counter.
REQ-025 The bit accepted in the same cycle as a cfg_load_i strobe SHALL be discarded, and that cycle SHALL produce no hit.
REQ-026 A cfg_load_i strobe with cfg_len_i < 2 or cfg_len_i > PAT_W SHALL leave the configuration unchanged and set cfg_err_o; cfg_err_o SHALL clear only on reset.
REQ-027 On each hit, match_cnt_o SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-028 When clr_cnt_i coincides with a hit, the counter SHALL become 1; clr_cnt_i alone SHALL set it to 0.

Reset
REQ-029 While rst_ni=0, match_o SHALL be 0, match_cnt_o 0, cfg_err_o 0, history 0 and fill 0; the pattern SHALL be RST_PAT, the length RST_LEN, and the mode non-overlapping.
REQ-030 Reset assertion mid-stream SHALL abort any partial match immediately; the first accepted bit after release counts as fill=1.

Structure
REQ-031 Package seq_det_pkg SHALL hold the default constants (RST_PAT, RST_LEN, PAT_W limits) and a function computing the length-mask from len.
REQ-032 The saturating counter SHALL be a single sub-module, sat_counter (parameter W; inputs inc and clr).
REQ-033 All other logic SHALL be flat in seq_detector_param; the RTL SHALL be synthesizable with no latches and no combinational feedback.

Verification
REQ-034 Reset defaults, non-overlapping mode, stream 1011_1011 -> match_o pulses once after bit 4 and once after bit 8; match_cnt_o=2.
REQ-035 Load pat=101, len=3, ovl=1; stream 10101 -> two pulses, after bits 3 and 5. Same stream with ovl=0 -> one pulse, after bit 3.
REQ-036 Default pattern, stream 1,0,1,1 with valid_i=0 gaps of 3 cycles between bits -> a single pulse one cycle after the 4th valid bit; gap cycles show match_o=0.
REQ-037 Load len=9 with PAT_W=8 -> cfg_err_o=1 and the old pattern still detected; then load len=1 -> cfg_err_o stays 1.
REQ-038 CNT_W=2, six matches -> match_cnt_o holds at 3; clr_cnt_i coincident with a hit -> 1.
REQ-039 rst_ni pulsed low after bits 101 of 1011, followed by bit 1 -> no pulse; full 1011 after release -> one pulse.
